// File: rtl/memoria_mmu.sv
// Word-addressed main memory behind the MMU, with toggle-based rdy/ack request and response channels.
// Optional write protection below LIM_PROT when MEMORIA_PROT_EN is defined.
module memoria_mmu #(
    parameter int N_IND    = 8,
    parameter int N_DATI   = 32,
    parameter int LAT      = 3,
    parameter int LIM_PROT = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rdyoutm,
    output logic              ackinm,
    input  logic [1:0]        opoutm,
    input  logic [N_IND-1:0]  indoutm,
    input  logic [N_DATI-1:0] dataout,
    output logic              rdyinm,
    input  logic              ackoutm,
    output logic              esitom,
    output logic [N_DATI-1:0] datain,
    output logic [1:0]        o_dbg_stato
);

    localparam logic [1:0] ATTESA   = 2'd0;
    localparam logic [1:0] ACCESSO  = 2'd1;
    localparam logic [1:0] RISPOSTA = 2'd2;

    localparam logic [3:0]     CNT_INIT = 4'(LAT - 1);
    localparam logic [N_IND:0] LIM_IND  = (N_IND + 1)'(LIM_PROT);

    logic [1:0]        r_stato;
    logic [3:0]        r_cnt;
    logic              r_rdy_vist;
    logic              r_ackinm;
    logic              r_rdyinm;
    logic              r_esitom;
    logic [N_DATI-1:0] r_datain;
    logic [1:0]        r_op;
    logic [N_IND-1:0]  r_ind;
    logic [N_DATI-1:0] r_dati;
    logic [N_DATI-1:0] r_mem [2**N_IND];

    logic w_req_pend;
    logic w_rsp_libero;
    logic w_fine;
    logic w_sotto_lim;
    logic w_prot;
    logic w_op_read;
    logic w_op_write;
    logic w_scrivi;

    // Both channels are level-transition handshakes: a request is pending while
    // rdyoutm differs from the last value seen, and the response channel is free
    // once the consumer has mirrored rdyinm onto ackoutm.
    assign w_req_pend   = (rdyoutm != r_rdy_vist);
    assign w_rsp_libero = (ackoutm == r_rdyinm);
    assign w_fine       = (r_stato == ACCESSO) && (r_cnt == 4'd0);
    assign w_op_read    = (r_op == 2'b00);
    assign w_op_write   = (r_op == 2'b01);
    assign w_sotto_lim  = ({1'b0, r_ind} < LIM_IND);

`ifdef MEMORIA_PROT_EN
    assign w_prot = w_sotto_lim;
`else
    // Without protection every address is writable and the limit is ignored.
    assign w_prot = w_sotto_lim & 1'b0;
`endif

    assign w_scrivi = w_fine && w_op_write && !w_prot;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stato    <= ATTESA;
            r_cnt      <= 4'd0;
            r_rdy_vist <= 1'b0;
            r_ackinm   <= 1'b0;
            r_rdyinm   <= 1'b0;
            r_esitom   <= 1'b0;
            r_datain   <= '0;
            r_op       <= 2'b00;
            r_ind      <= '0;
            r_dati     <= '0;
        end else begin
            case (r_stato)
                ATTESA: begin
                    if (w_req_pend && w_rsp_libero) begin
                        r_op       <= opoutm;
                        r_ind      <= indoutm;
                        r_dati     <= dataout;
                        r_ackinm   <= ~r_ackinm;
                        r_rdy_vist <= rdyoutm;
                        r_cnt      <= CNT_INIT;
                        r_stato    <= ACCESSO;
                    end
                end
                ACCESSO: begin
                    if (r_cnt == 4'd0) begin
                        r_rdyinm <= ~r_rdyinm;
                        r_stato  <= RISPOSTA;
                        if (w_op_read) begin
                            r_datain <= r_mem[r_ind];
                            r_esitom <= 1'b0;
                        end else if (w_op_write && !w_prot) begin
                            r_datain <= '0;
                            r_esitom <= 1'b0;
                        end else begin
                            r_datain <= '0;
                            r_esitom <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RISPOSTA: begin
                    if (w_rsp_libero) begin
                        r_stato <= ATTESA;
                    end
                end
                default: r_stato <= ATTESA;
            endcase
        end
    end

    // The array has no reset; an aborted access never reaches w_scrivi.
    always_ff @(posedge clock) begin
        if (w_scrivi) begin
            r_mem[r_ind] <= r_dati;
        end
    end

    assign ackinm      = r_ackinm;
    assign rdyinm      = r_rdyinm;
    assign esitom      = r_esitom;
    assign datain      = r_datain;
    assign o_dbg_stato = r_stato;

endmodule

// File: tb/tb_memoria_mmu.sv
// Self-checking bench for memoria_mmu: directed handshake/timing steps plus randomized traffic
// checked against an associative-array memory model.
module tb_memoria_mmu;

    localparam int N_IND  = 8;
    localparam int N_DATI = 32;
    localparam int LAT    = 3;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              rdyoutm;
    logic              ackinm;
    logic [1:0]        opoutm;
    logic [N_IND-1:0]  indoutm;
    logic [N_DATI-1:0] dataout;
    logic              rdyinm;
    logic              ackoutm;
    logic              esitom;
    logic [N_DATI-1:0] datain;
    logic [1:0]        o_dbg_stato;

    int n_chk  = 0;
    int n_fail = 0;

    logic [N_DATI-1:0] mem_mod [int];
    logic [N_DATI:0]   exp_q[$];
    logic [N_DATI:0]   last_rsp;
    logic              exp_ack;
    logic              exp_rdy;

    always #5 clock = ~clock;

    memoria_mmu #(
        .N_IND   (N_IND),
        .N_DATI  (N_DATI),
        .LAT     (LAT),
        .LIM_PROT(16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rdyoutm    (rdyoutm),
        .ackinm     (ackinm),
        .opoutm     (opoutm),
        .indoutm    (indoutm),
        .dataout    (dataout),
        .rdyinm     (rdyinm),
        .ackoutm    (ackoutm),
        .esitom     (esitom),
        .datain     (datain),
        .o_dbg_stato(o_dbg_stato)
    );

    task automatic chk(input string tag, input logic [N_DATI:0] obs, input logic [N_DATI:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference behaviour: returns {esito, datain} and updates the model memory.
    task automatic modello(input logic [1:0] op, input logic [N_IND-1:0] ind,
                           input logic [N_DATI-1:0] dati, output logic [N_DATI:0] rsp);
        bit protetto;
        protetto = 1'b0;
`ifdef MEMORIA_PROT_EN
        protetto = (int'(ind) < 16);
`endif
        if (op == 2'b00) begin
            rsp = {1'b0, mem_mod[int'(ind)]};
        end else if (op == 2'b01 && !protetto) begin
            mem_mod[int'(ind)] = dati;
            rsp = '0;
        end else begin
            rsp = {1'b1, {N_DATI{1'b0}}};
        end
    endtask

    task automatic invia(input logic [1:0] op, input logic [N_IND-1:0] ind, input logic [N_DATI-1:0] dati);
        logic [N_DATI:0] rsp;
        opoutm  = op;
        indoutm = ind;
        dataout = dati;
        rdyoutm = ~rdyoutm;
        modello(op, ind, dati, rsp);
        exp_q.push_back(rsp);
    endtask

    task automatic attendi_ack(input int atteso, input string tag);
        int c;
        c = 0;
        exp_ack = ~exp_ack;
        while (ackinm !== exp_ack && c < 20) begin
            @(posedge clock); #1;
            c++;
        end
        chk({tag, " ack_cicli"}, (N_DATI+1)'(c), (N_DATI+1)'(atteso));
    endtask

    task automatic attendi_rsp(input string tag);
        int c;
        logic [N_DATI:0] e;
        c = 0;
        exp_rdy = ~exp_rdy;
        while (rdyinm !== exp_rdy && c < 40) begin
            @(posedge clock); #1;
            c++;
        end
        chk({tag, " rsp_cicli"}, (N_DATI+1)'(c), (N_DATI+1)'(LAT));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        last_rsp = e;
        chk({tag, " rsp"}, {esitom, datain}, e);
    endtask

    task automatic consuma(input int ritardo, input string tag);
        for (int i = 0; i < ritardo; i++) begin
            @(posedge clock); #1;
            chk({tag, " stabile"}, {esitom, datain}, last_rsp);
            chk({tag, " no_ack"}, {{N_DATI{1'b0}}, ackinm}, {{N_DATI{1'b0}}, exp_ack});
        end
        @(negedge clock);
        ackoutm = ~ackoutm;
    endtask

    task automatic transazione(input logic [1:0] op, input logic [N_IND-1:0] ind,
                               input logic [N_DATI-1:0] dati, input int ritardo, input string tag);
        @(negedge clock);
        invia(op, ind, dati);
        attendi_ack(1, tag);
        attendi_rsp(tag);
        consuma(ritardo, tag);
        @(posedge clock); #1;
    endtask

    task automatic controlla_zero(input string tag);
        chk({tag, " ackinm"}, {{N_DATI{1'b0}}, ackinm}, '0);
        chk({tag, " rdyinm"}, {{N_DATI{1'b0}}, rdyinm}, '0);
        chk({tag, " esito_dati"}, {esitom, datain}, '0);
    endtask

    initial begin
        logic [1:0]        op;
        logic [N_IND-1:0]  ind;
        logic [N_DATI-1:0] dati;
        int                sel;

        reset_n = 1'b0;
        rdyoutm = 1'b0;
        ackoutm = 1'b0;
        opoutm  = 2'b00;
        indoutm = '0;
        dataout = '0;
        exp_ack = 1'b0;
        exp_rdy = 1'b0;
        last_rsp = '0;

        // Reset then idle
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        controlla_zero("reset");
        chk("reset stato", {{(N_DATI-1){1'b0}}, o_dbg_stato}, '0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            controlla_zero("idle");
        end

        // Write then read
        transazione(2'b01, 8'h20, 32'hDEADBEEF, 0, "scrivi_20");
        transazione(2'b00, 8'h20, 32'h0, 0, "leggi_20");

        // Illegal operations leave the array untouched
        transazione(2'b01, 8'h05, 32'h11111111, 1, "prep_05");
        transazione(2'b10, 8'h05, 32'hFFFFFFFF, 0, "illegale_10");
        transazione(2'b11, 8'h05, 32'h22222222, 0, "illegale_11");
        transazione(2'b00, 8'h05, 32'h0, 0, "leggi_05");

        // Low addresses: faults only with protection enabled
        transazione(2'b01, 8'h03, 32'h00000777, 0, "prep_03");
        transazione(2'b01, 8'h03, 32'h00001234, 0, "scrivi_03");
        transazione(2'b00, 8'h03, 32'h0, 0, "leggi_03");
        transazione(2'b01, 8'h10, 32'h00C0FFEE, 0, "scrivi_10");
        transazione(2'b00, 8'h10, 32'h0, 0, "leggi_10");
        transazione(2'b00, 8'h0F, 32'h0, 0, "leggi_0f_prima");
        transazione(2'b01, 8'hFF, 32'hA5A5A5A5, 0, "scrivi_ff");
        transazione(2'b00, 8'hFF, 32'h0, 0, "leggi_ff");

        // Back-pressure with a second request already waiting
        @(negedge clock);
        invia(2'b01, 8'h40, 32'h01234567);
        attendi_ack(1, "bp_primo");
        attendi_rsp("bp_primo");
        @(negedge clock);
        invia(2'b00, 8'h40, 32'h0);
        consuma(7, "bp");
        attendi_ack(2, "bp_secondo");
        attendi_rsp("bp_secondo");
        consuma(0, "bp_secondo");
        @(posedge clock); #1;

        // Response ack and new request in the same cycle
        @(negedge clock);
        invia(2'b01, 8'h41, 32'h89ABCDEF);
        attendi_ack(1, "sim_primo");
        attendi_rsp("sim_primo");
        @(negedge clock);
        ackoutm = ~ackoutm;
        invia(2'b00, 8'h41, 32'h0);
        attendi_ack(2, "sim_secondo");
        attendi_rsp("sim_secondo");
        consuma(0, "sim_secondo");
        @(posedge clock); #1;

        // Reset in the middle of a write
        transazione(2'b01, 8'h30, 32'h000000AA, 0, "prep_30");
        @(negedge clock);
        invia(2'b01, 8'h30, 32'h00000055);
        exp_q.delete();
        mem_mod[32'h30] = 32'h000000AA;
        attendi_ack(1, "abort");
        @(posedge clock); #1;
        chk("abort in_accesso", {{(N_DATI-1){1'b0}}, o_dbg_stato}, 33'd1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        controlla_zero("abort");
        rdyoutm = 1'b0;
        ackoutm = 1'b0;
        exp_ack = 1'b0;
        exp_rdy = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        transazione(2'b00, 8'h30, 32'h0, 0, "leggi_30");

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            sel  = $urandom_range(0, 9);
            ind  = N_IND'($urandom_range(0, 255));
            dati = $urandom;
            if (sel < 5) begin
                op = 2'b00;
                if (!mem_mod.exists(int'(ind))) op = 2'b01;
            end else if (sel < 9) begin
                op = 2'b01;
            end else begin
                op = 2'($urandom_range(2, 3));
            end
            transazione(op, ind, dati, $urandom_range(0, 3), "casuale");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
